// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the miniRV instruction-fetch sequencer.
// The FSM state encoding and the alignment helper live here so both RTL files agree.
package pc_seq_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSN_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // Instruction addresses must be word aligned; only the two low bits matter.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap vector beats an aligned redirect, which beats pc+4.
// A misaligned redirect never wins and is reported so the sequencer can flag it.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            take_o,
  output logic            misaligned_hit_o
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] trap_target;
  logic            redirect_ok;

  // pc+4 wraps naturally at the top of the address space.
  assign seq_pc      = pc_i + XLEN'(INSN_BYTES);
  assign trap_target = trap_vector_i & ~XLEN'(INSN_BYTES - 1);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    redirect_ok      = redirect_valid_i && is_aligned(redirect_addr_i[1:0]);
    take_o           = trap_valid_i || redirect_ok;
    misaligned_hit_o = redirect_valid_i && !trap_valid_i && !is_aligned(redirect_addr_i[1:0]);
    next_pc_o        = seq_pc;
    if (trap_valid_i) begin
      next_pc_o = trap_target;
    end else if (redirect_ok) begin
      next_pc_o = redirect_addr_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Sequenced instruction fetch: one outstanding imem request, a holding register
// towards decode, and trap/redirect steering with stale-response dropping.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] INITIAL_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            misaligned,
  output logic [XLEN-1:0] pc
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] sel_next_pc;
  logic            sel_take;
  logic            sel_misaligned;

  pc_next_sel #(
    .XLEN(XLEN)
  ) u_next_sel (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .redirect_addr_i  (redirect_addr),
    .trap_valid_i     (trap_valid),
    .trap_vector_i    (trap_vector),
    .next_pc_o        (sel_next_pc),
    .take_o           (sel_take),
    .misaligned_hit_o (sel_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    misaligned_d = sel_misaligned && (state_q != ST_BOOT);

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (sel_take) begin
          pc_d = sel_next_pc;
        end
        // A redirect in the accept cycle leaves a response in flight for the old pc.
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = sel_take;
        end
      end

      ST_WAIT: begin
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          if (sel_take) begin
            pc_d    = sel_next_pc;
            state_d = ST_REQ;
          end else if (drop_q) begin
            state_d = ST_REQ;
          end else begin
            inst_data_d = imem_resp_data;
            inst_pc_d   = pc_q;
            state_d     = ST_HOLD;
          end
        end else if (sel_take) begin
          pc_d   = sel_next_pc;
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // Without a take, sel_next_pc is pc+4, so consume and steer share one path.
        if (sel_take || inst_ready) begin
          pc_d    = sel_next_pc;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and ordering between always_ff blocks cannot matter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= INITIAL_PC;
      drop_q       <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == ST_HOLD);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign misaligned     = misaligned_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios pinned to literal values plus a
// randomized run compared every cycle against a transaction-level fetch model.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        misaligned;
  logic [31:0] pc;

  pc_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .misaligned      (misaligned),
    .pc              (pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model: fetch viewed as transactions ----------------
  typedef struct packed {
    logic        boot;   // first cycle after reset release
    logic [31:0] pc;
    logic        out;    // a request has been accepted and its response is pending
    logic        stale;  // the pending response belongs to an abandoned pc
    logic        have;   // an instruction is parked for decode
    logic [31:0] data;
    logic [31:0] ipc;
    logic        mis;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r      = '0;
    r.boot = 1'b1;
    r.pc   = 32'h8000_0000;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t      n;
    logic        take;
    logic [31:0] tgt;
    n    = s;
    take = trap_valid || (redirect_valid && (redirect_addr % 4 == 0));
    tgt  = trap_valid ? (trap_vector - (trap_vector % 4)) : redirect_addr;
    n.mis = !s.boot && redirect_valid && !trap_valid && (redirect_addr % 4 != 0);
    if (s.boot) begin
      n.boot = 1'b0;
    end else if (s.have) begin
      if (take) begin
        n.pc = tgt; n.have = 1'b0;
      end else if (inst_ready) begin
        n.pc = s.pc + 32'd4; n.have = 1'b0;
      end
    end else if (s.out) begin
      if (imem_resp_valid) begin
        n.out = 1'b0; n.stale = 1'b0;
        if (take) n.pc = tgt;
        else if (!s.stale) begin
          n.have = 1'b1; n.data = imem_resp_data; n.ipc = s.pc;
        end
      end else if (take) begin
        n.pc = tgt; n.stale = 1'b1;
      end
    end else begin
      if (take) n.pc = tgt;
      if (imem_req_ready) begin
        n.out = 1'b1; n.stale = take;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m);
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("req_valid",  32'(imem_req_valid), 32'(!m.boot && !m.out && !m.have));
      check("req_addr",   imem_req_addr, m.pc);
      check("pc",         pc, m.pc);
      check("inst_valid", 32'(inst_valid), 32'(m.have));
      check("inst_data",  inst_data, m.data);
      check("inst_pc",    inst_pc, m.ipc);
      check("misaligned", 32'(misaligned), 32'(m.mis));
      check("req_inst_exclusive", 32'(imem_req_valid && inst_valid), 32'd0);
    end
  end

  // ---------------- Memory responder ----------------
  logic        acc_n = 1'b0;
  int          resp_delay_cfg = 1;
  bit          rand_delay = 1'b0;
  bit          rand_data  = 1'b0;
  logic [31:0] resp_word_cfg = 32'h0000_0013;
  int          flush_req  = 0;

  initial forever begin
    @(negedge clock);
    acc_n = imem_req_valid && imem_req_ready;
  end

  initial begin
    int cnt;
    int flush_seen;
    bit fire;
    cnt = 0;
    flush_seen = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clock);
      if (acc_n) cnt = rand_delay ? int'($urandom_range(1, 3)) : resp_delay_cfg;
      if (flush_req != flush_seen) begin
        cnt = 0;
        flush_seen = flush_req;
      end
      #2;
      fire = 1'b0;
      if (cnt > 0) begin
        cnt--;
        fire = (cnt == 0);
      end
      imem_resp_valid = fire;
      imem_resp_data  = (fire && !rand_data) ? resp_word_cfg : $urandom();
    end
  end

  // ---------------- Handshake log for cadence checks ----------------
  int          cyc = 0;
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];
  logic [31:0] inst_pc_log[$];
  logic [31:0] inst_data_log[$];

  always @(posedge clock) cyc <= cyc + 1;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        req_addr_log.push_back(imem_req_addr);
        req_cyc_log.push_back(cyc);
      end
      if (inst_valid && inst_ready) begin
        inst_pc_log.push_back(inst_pc);
        inst_data_log.push_back(inst_data);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input int delay, input logic [31:0] word, input logic rdy);
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = rdy;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    trap_valid     = 1'b0;
    trap_vector    = 32'h0;
    resp_delay_cfg = delay;
    resp_word_cfg  = word;
    rand_delay     = 1'b0;
    rand_data      = 1'b0;
    flush_req++;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imem_req_valid) break;
    end
    check(name, 32'(imem_req_valid), 32'd1);
  endtask

  task automatic wait_hold(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (inst_valid) break;
    end
    check(name, 32'(inst_valid), 32'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0:       a = 32'hFFFF_FFFC;
      1:       a = 32'h8000_0000 + ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
      default: a = 32'h8000_0000 + ($urandom_range(0, 255) * 4);
    endcase
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- Main sequence ----------------
  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    trap_valid     = 1'b0;
    trap_vector    = 32'h0;
    tick(2);

    // Reset values.
    check("rst_pc",         pc, 32'h8000_0000);
    check("rst_req_valid",  32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data",  inst_data, 32'd0);
    check("rst_inst_pc",    inst_pc, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);

    // Zero-wait memory, decode always ready: 3-cycle cadence.
    do_reset(1, 32'h0000_0013, 1'b1);
    req_addr_log.delete(); req_cyc_log.delete();
    inst_pc_log.delete();  inst_data_log.delete();
    tick(12);
    check("t1_req_count",  32'(req_addr_log.size() >= 3), 32'd1);
    check("t1_inst_count", 32'(inst_pc_log.size() >= 3), 32'd1);
    if (req_addr_log.size() >= 3 && inst_pc_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_req_addr",  req_addr_log[i], 32'h8000_0000 + 32'(4 * i));
        check("t1_inst_pc",   inst_pc_log[i],  32'h8000_0000 + 32'(4 * i));
        check("t1_inst_data", inst_data_log[i], 32'h0000_0013);
      end
      check("t1_cadence_a", 32'(req_cyc_log[1] - req_cyc_log[0]), 32'd3);
      check("t1_cadence_b", 32'(req_cyc_log[2] - req_cyc_log[1]), 32'd3);
    end

    // Decode stalls for 5 cycles: held instruction stays put, no new request.
    do_reset(1, 32'hDEAD_0013, 1'b0);
    wait_hold("t2_hold_reached");
    for (int i = 0; i < 5; i++) begin
      check("t2_inst_valid", 32'(inst_valid), 32'd1);
      check("t2_inst_data",  inst_data, 32'hDEAD_0013);
      check("t2_inst_pc",    inst_pc, 32'h8000_0000);
      check("t2_pc",         pc, 32'h8000_0000);
      check("t2_no_req",     32'(imem_req_valid), 32'd0);
      @(negedge clock);
    end
    tick(1);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;

    // Redirect while waiting: the late response is dropped.
    do_reset(3, 32'h1111_0013, 1'b1);
    wait_req("t3_first_req");
    tick(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h8000_0100;
    tick(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_no_inst", 32'(inst_valid), 32'd0);
      if (imem_req_valid) break;
    end
    check("t3_refetch",      32'(imem_req_valid), 32'd1);
    check("t3_refetch_addr", imem_req_addr, 32'h8000_0100);

    // Trap and redirect together in HOLD: trap wins, vector low bits cleared.
    do_reset(1, 32'h2222_0013, 1'b0);
    wait_hold("t4_hold_reached");
    tick(1);
    trap_valid     = 1'b1;
    trap_vector    = 32'h8000_0203;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h8000_0040;
    tick(1);
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    wait_req("t4_req_after_trap");
    check("t4_trap_addr",  imem_req_addr, 32'h8000_0200);
    check("t4_no_misalign", 32'(misaligned), 32'd0);

    // Misaligned redirect in HOLD: ignored, one-cycle flag.
    do_reset(1, 32'h3333_0013, 1'b0);
    wait_hold("t5_hold_reached");
    tick(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h8000_0042;
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clock);
    check("t5_mis_pulse",  32'(misaligned), 32'd1);
    check("t5_still_held", 32'(inst_valid), 32'd1);
    check("t5_pc_kept",    pc, 32'h8000_0000);
    check("t5_inst_pc",    inst_pc, 32'h8000_0000);
    @(negedge clock);
    check("t5_mis_end",    32'(misaligned), 32'd0);
    check("t5_held_after", 32'(inst_valid), 32'd1);

    // pc+4 wraps from the top of the address space.
    do_reset(1, 32'h4444_0013, 1'b0);
    wait_hold("t6_hold_reached");
    tick(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    wait_req("t6_req_top");
    check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(1);
    wait_req("t6_req_wrap");
    check("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset mid-WAIT; the in-flight response lands after release and is ignored.
    do_reset(3, 32'h5555_0013, 1'b1);
    wait_req("t7_first_req");
    tick(1);
    reset = 1'b0;
    #1;
    check("t7_rst_req_valid",  32'(imem_req_valid), 32'd0);
    check("t7_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t7_rst_pc",         pc, 32'h8000_0000);
    check("t7_rst_inst_data",  inst_data, 32'd0);
    tick(1);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t7_req_during_stray", 32'(imem_req_valid), 32'd1);
    @(negedge clock);
    check("t7_stray_ignored", 32'(inst_valid), 32'd0);
    tick(6);

    // Randomized run against the model.
    do_reset(1, 32'h0, 1'b1);
    rand_delay = 1'b1;
    rand_data  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 4) < 3);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = pick_addr();
      trap_valid     = ($urandom_range(0, 19) == 0);
      trap_vector    = $urandom();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
